// File: rtl/div_if.sv
// Divider request/response bundle: operands and destination in, write-back and busy out.
interface div_if;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned ADDR_W = 5;

  logic [XLEN-1:0]   dividend_i;
  logic [XLEN-1:0]   divisor_i;
  logic [OP_W-1:0]   op_i;
  logic [ADDR_W-1:0] reg_waddr_i;
  logic              start_i;
  logic              flush_i;
  logic [XLEN-1:0]   result_o;
  logic              ready_o;
  logic [ADDR_W-1:0] reg_waddr_o;
  logic              busy_o;

  modport master (
    output dividend_i, divisor_i, op_i, reg_waddr_i, start_i, flush_i,
    input  result_o, ready_o, reg_waddr_o, busy_o
  );

  modport slave (
    input  dividend_i, divisor_i, op_i, reg_waddr_i, start_i, flush_i,
    output result_o, ready_o, reg_waddr_o, busy_o
  );
endinterface

// File: rtl/div.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit: restoring shift-subtract, one quotient bit per clock.
module div (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);
  localparam int unsigned XLEN   = 32;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 5;

  localparam logic [OP_W-1:0] OP_DIV  = 3'b100;
  localparam logic [OP_W-1:0] OP_REM  = 3'b110;
  localparam logic [OP_W-1:0] OP_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    CALC  = 2'd2
  } state_t;

  state_t            state;
  logic [XLEN-1:0]   dividend_r;
  logic [XLEN-1:0]   divisor_r;
  logic [OP_W-1:0]   op_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [XLEN-1:0]   quo_sh;
  logic [XLEN-1:0]   dvs_mag;
  logic [XLEN-1:0]   rem;
  logic [CNT_W-1:0]  cnt;

  logic              is_signed;
  logic              is_rem;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN-1:0]   abs_a;
  logic [XLEN-1:0]   abs_b;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   quo_next;
  logic [XLEN-1:0]   rem_next;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;

  // Operand decode, magnitudes and one restoring step. quo_sh holds the dividend magnitude
  // at first and fills with quotient bits from the bottom as dividend bits leave the top.
  always_comb begin
    is_signed = (op_r == OP_DIV) || (op_r == OP_REM);
    is_rem    = (op_r == OP_REM) || (op_r == OP_REMU);
    neg_a     = is_signed & dividend_r[XLEN-1];
    neg_b     = is_signed & divisor_r[XLEN-1];
    abs_a     = neg_a ? -dividend_r : dividend_r;
    abs_b     = neg_b ? -divisor_r  : divisor_r;

    // 33-bit partial remainder so the borrow of the trial subtract is never lost
    rem_shift = {rem, quo_sh[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs_mag};
    quo_next  = {quo_sh[XLEN-2:0], ~diff[XLEN]};
    rem_next  = diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0];

    quo_fix   = (neg_a ^ neg_b) ? -quo_next : quo_next;
    rem_fix   = neg_a ? -rem_next : rem_next;
  end

  // Control FSM; flush wins over everything, ready_o is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      dividend_r      <= '0;
      divisor_r       <= '0;
      op_r            <= '0;
      waddr_r         <= '0;
      quo_sh          <= '0;
      dvs_mag         <= '0;
      rem             <= '0;
      cnt             <= '0;
      bus.result_o    <= '0;
      bus.ready_o     <= 1'b0;
      bus.reg_waddr_o <= '0;
      bus.busy_o      <= 1'b0;
    end else begin
      bus.ready_o <= 1'b0;
      if (bus.flush_i) begin
        state      <= IDLE;
        bus.busy_o <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start_i) begin
              dividend_r <= bus.dividend_i;
              divisor_r  <= bus.divisor_i;
              op_r       <= bus.op_i;
              waddr_r    <= bus.reg_waddr_i;
              bus.busy_o <= 1'b1;
              state      <= START;
            end
          end
          START: begin
            if (divisor_r == '0) begin
              bus.result_o    <= is_rem ? dividend_r : '1;
              bus.ready_o     <= 1'b1;
              bus.reg_waddr_o <= waddr_r;
              bus.busy_o      <= 1'b0;
              state           <= IDLE;
            end else begin
              quo_sh  <= abs_a;
              dvs_mag <= abs_b;
              rem     <= '0;
              cnt     <= '0;
              state   <= CALC;
            end
          end
          CALC: begin
            quo_sh <= quo_next;
            rem    <= rem_next;
            cnt    <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN - 1)) begin
              bus.result_o    <= is_rem ? rem_fix : quo_fix;
              bus.ready_o     <= 1'b1;
              bus.reg_waddr_o <= waddr_r;
              bus.busy_o      <= 1'b0;
              state           <= IDLE;
            end
          end
          default: begin
            state      <= IDLE;
            bus.busy_o <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_div.sv
// Directed-vector bench for div: hand-computed results, latencies, flush, back-to-back and reset.
module tb_div;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  div_if bus();

  div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the next rising edge is the acceptance edge E0.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wa);
    bus.op_i        = op;
    bus.dividend_i  = a;
    bus.divisor_i   = b;
    bus.reg_waddr_i = wa;
    bus.start_i     = 1'b1;
    @(negedge clk);
    bus.start_i     = 1'b0;
  endtask

  // Edges after E0 until ready_o is seen, bounded.
  task automatic wait_ready(output int lat);
    lat = 0;
    while (bus.ready_o !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic count_ready(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.ready_o === 1'b1) n++;
    end
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wa,
                       input logic [31:0] exp, input int exp_lat);
    int lat;
    issue(op, a, b, wa);
    check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
    wait_ready(lat);
    check({tag, "_lat"},   32'(lat), 32'(exp_lat));
    check({tag, "_res"},   bus.result_o, exp);
    check({tag, "_waddr"}, 32'(bus.reg_waddr_o), 32'(wa));
    check({tag, "_idle"},  32'(bus.busy_o), 32'd0);
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus.ready_o), 32'd0);
    check({tag, "_hold"},  bus.result_o, exp);
  endtask

  initial begin
    int lat;
    int n;
    rst             = 1'b0;
    bus.dividend_i  = '0;
    bus.divisor_i   = '0;
    bus.op_i        = '0;
    bus.reg_waddr_i = '0;
    bus.start_i     = 1'b0;
    bus.flush_i     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_result", bus.result_o, 32'd0);
    check("rst_ready",  32'(bus.ready_o), 32'd0);
    check("rst_busy",   32'(bus.busy_o), 32'd0);
    check("rst_waddr",  32'(bus.reg_waddr_o), 32'd0);
    rst = 1'b1;

    // first acceptance right at the first edge after release
    do_op("div_100_7",   OP_DIV,  32'd100,        32'd7,        5'd5,  32'd14,        33);
    do_op("rem_100_7",   OP_REM,  32'd100,        32'd7,        5'd6,  32'd2,         33);
    do_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9,  32'd2,        5'd7,  32'hFFFF_FFFD, 33);
    do_op("rem_m7_2",    OP_REM,  32'hFFFF_FFF9,  32'd2,        5'd8,  32'hFFFF_FFFF, 33);
    do_op("divu_big_2",  OP_DIVU, 32'hFFFF_FFF9,  32'd2,        5'd9,  32'h7FFF_FFFC, 33);
    do_op("divu_5_0",    OP_DIVU, 32'd5,          32'd0,        5'd10, 32'hFFFF_FFFF, 1);
    do_op("remu_5_0",    OP_REMU, 32'd5,          32'd0,        5'd11, 32'd5,         1);
    do_op("rem_m5_0",    OP_REM,  32'hFFFF_FFFB,  32'd0,        5'd13, 32'hFFFF_FFFB, 1);
    do_op("div_ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 33);
    do_op("rem_ovf",     OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'd0,        33);
    do_op("rem_7_m2",    OP_REM,  32'd7,          32'hFFFF_FFFE, 5'd16, 32'd1,        33);
    do_op("remu_big",    OP_REMU, 32'hFFFF_FFFF,  32'd10,       5'd17, 32'd5,         33);
    do_op("div_7_m2",    OP_DIV,  32'd7,          32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 33);

    // flush at E10, new request at E11
    issue(OP_DIV, 32'd1000, 32'd3, 5'd20);
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_busy",  32'(bus.busy_o), 32'd0);
    check("flush_ready", 32'(bus.ready_o), 32'd0);
    check("flush_res",   bus.result_o, 32'hFFFF_FFFD);
    check("flush_waddr", 32'(bus.reg_waddr_o), 32'd12);
    do_op("after_flush", OP_DIV, 32'd9, 32'd3, 5'd3, 32'd3, 33);

    // flush and start together: flush wins
    bus.op_i = OP_DIV; bus.dividend_i = 32'd50; bus.divisor_i = 32'd5; bus.reg_waddr_i = 5'd7;
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    check("flush_prio_busy", 32'(bus.busy_o), 32'd0);
    count_ready(40, n);
    check("flush_prio_noready", 32'(n), 32'd0);
    check("flush_prio_res", bus.result_o, 32'd3);

    // back-to-back: second start during the ready cycle
    issue(OP_DIV, 32'd100, 32'd7, 5'd1);
    wait_ready(lat);
    check("b2b_a_lat", 32'(lat), 32'd33);
    check("b2b_a_res", bus.result_o, 32'd14);
    issue(OP_REMU, 32'd100, 32'd7, 5'd2);
    check("b2b_b_busy", 32'(bus.busy_o), 32'd1);
    check("b2b_b_pulse", 32'(bus.ready_o), 32'd0);
    wait_ready(lat);
    check("b2b_b_lat",   32'(lat), 32'd33);
    check("b2b_b_res",   bus.result_o, 32'd2);
    check("b2b_b_waddr", 32'(bus.reg_waddr_o), 32'd2);

    // asynchronous reset at E15 of an operation
    @(negedge clk);
    issue(OP_DIV, 32'd100, 32'd7, 5'd5);
    repeat (14) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("arst_result", bus.result_o, 32'd0);
    check("arst_ready",  32'(bus.ready_o), 32'd0);
    check("arst_busy",   32'(bus.busy_o), 32'd0);
    check("arst_waddr",  32'(bus.reg_waddr_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    count_ready(40, n);
    check("arst_noready", 32'(n), 32'd0);
    check("arst_busy_after", 32'(bus.busy_o), 32'd0);
    do_op("after_rst", OP_DIVU, 32'd1000, 32'd10, 5'd31, 32'd100, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
